// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the IF/DM memory port arbiter.
package mem_arb_pkg;

    localparam int unsigned DEF_DATA_W    = 32;
    localparam int unsigned DEF_ADDR_W    = 32;
    localparam int unsigned DEF_MEM_DEPTH = 128;
    localparam int unsigned DEF_MAX_WAIT  = 4;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    typedef enum logic [0:0] {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_arb_prio.sv
// Winner select between IF and DM with an IF starvation counter.
module mem_arb_prio
    import mem_arb_pkg::*;
#(
    parameter int unsigned MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic clk,
    input  logic rst,
    input  logic arb_en,
    input  logic if_req,
    input  logic dm_req,
    output logic if_win_c
);

    localparam int unsigned CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

    logic [CNT_W-1:0] starve_cnt_q;
    logic [CNT_W-1:0] starve_cnt_d;
    logic             starved;

    // IF wins when DM is absent or IF has lost MAX_WAIT arbitrations in a row
    always_comb begin
        starved  = (starve_cnt_q == CNT_W'(MAX_WAIT));
        if_win_c = if_req && (!dm_req || starved);
    end

    // Count IF losses (saturating); clear on IF grant or when IF stops asking
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!if_req) begin
            starve_cnt_d = '0;
        end else if (arb_en) begin
            if (if_win_c) begin
                starve_cnt_d = '0;
            end else if (!starved) begin
                starve_cnt_d = starve_cnt_q + CNT_W'(1);
            end
        end
    end

    // Starvation counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-cycle shared memory port between instruction fetch and the data stage.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned MEM_DEPTH = DEF_MEM_DEPTH,
    parameter int unsigned MAX_WAIT  = DEF_MAX_WAIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_valid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              addr_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    state_e            state_q,     state_d;
    owner_e            owner_q,     owner_d;
    logic              err_q,       err_d;
    logic              wr_q,        wr_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic              mem_we_q,    mem_we_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              if_gnt_q,    if_gnt_d;
    logic              dm_gnt_q,    dm_gnt_d;
    logic              if_valid_q,  if_valid_d;
    logic              dm_valid_q,  dm_valid_d;
    logic              addr_err_q,  addr_err_d;
    logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q,  dm_rdata_d;

    logic              arb_en;
    logic              if_win_c;
    logic              if_oor;
    logic              dm_oor;
    logic [DATA_W-1:0] rd_data;

    assign arb_en = (state_q == IDLE) && (if_req || dm_req);

    mem_arb_prio #(
        .MAX_WAIT (MAX_WAIT)
    ) u_prio (
        .clk      (clk),
        .rst      (rst),
        .arb_en   (arb_en),
        .if_req   (if_req),
        .dm_req   (dm_req),
        .if_win_c (if_win_c)
    );

    // Range checks on the full address width; out-of-range reads return zero
    always_comb begin
        if_oor  = (if_addr >= ADDR_W'(MEM_DEPTH));
        dm_oor  = (dm_addr >= ADDR_W'(MEM_DEPTH));
        rd_data = err_q ? '0 : mem_rdata;
    end

    // Next-state and response logic: grant in IDLE, complete in ACCESS
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        err_d       = err_q;
        wr_d        = wr_q;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
        if_gnt_d    = 1'b0;
        dm_gnt_d    = 1'b0;
        if_valid_d  = 1'b0;
        dm_valid_d  = 1'b0;
        addr_err_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;

        unique case (state_q)
            IDLE: begin
                if (arb_en) begin
                    state_d = ACCESS;
                    if (if_win_c) begin
                        owner_d    = OWN_IF;
                        mem_addr_d = if_addr;
                        wr_d       = 1'b0;
                        err_d      = if_oor;
                        if_gnt_d   = 1'b1;
                    end else begin
                        owner_d     = OWN_DM;
                        mem_addr_d  = dm_addr;
                        mem_wdata_d = dm_wdata;
                        wr_d        = dm_we;
                        err_d       = dm_oor;
                        mem_we_d    = dm_we && !dm_oor;
                        dm_gnt_d    = 1'b1;
                    end
                end
            end
            ACCESS: begin
                state_d    = IDLE;
                addr_err_d = err_q;
                if (owner_q == OWN_IF) begin
                    if_valid_d = 1'b1;
                    if_rdata_d = rd_data;
                end else begin
                    dm_valid_d = 1'b1;
                    if (!wr_q) begin
                        dm_rdata_d = rd_data;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset aborts any access in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= OWN_IF;
            err_q       <= 1'b0;
            wr_q        <= 1'b0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            if_gnt_q    <= 1'b0;
            dm_gnt_q    <= 1'b0;
            if_valid_q  <= 1'b0;
            dm_valid_q  <= 1'b0;
            addr_err_q  <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            err_q       <= err_d;
            wr_q        <= wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            if_gnt_q    <= if_gnt_d;
            dm_gnt_q    <= dm_gnt_d;
            if_valid_q  <= if_valid_d;
            dm_valid_q  <= dm_valid_d;
            addr_err_q  <= addr_err_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

    assign if_gnt    = if_gnt_q;
    assign dm_gnt    = dm_gnt_q;
    assign if_valid  = if_valid_q;
    assign dm_valid  = dm_valid_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign addr_err  = addr_err_q;
    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = (state_q != IDLE);

endmodule
